// File: rtl/sram_piso_reader.sv
// Reads one SRAM row on request and streams the captured word out serially,
// LSB first, under a valid/ready handshake. All outputs are registered.
module sram_piso_reader #(
  parameter int ROWS    = 16,
  parameter int COLS    = 8,
  parameter int TIMEOUT = 15,
  localparam int AW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int WW = $clog2(TIMEOUT + 1)
) (
  input  logic            clk,
  input  logic            arst_n,
  input  logic            req,
  input  logic [AW-1:0]   req_addr,
  output logic            req_ready,
  output logic            sram_r_en,
  output logic [AW-1:0]   sram_addr,
  input  logic            sram_data_valid,
  input  logic [COLS-1:0] sram_data_out,
  output logic            serial_out,
  output logic            ser_valid,
  input  logic            ser_ready,
  output logic            ser_last,
  output logic            addr_err,
  output logic            timeout_err
);

  typedef enum logic [1:0] {IDLE, READ, SHIFT} state_t;

  localparam logic [CW-1:0] LAST_BIT = CW'(COLS - 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(TIMEOUT - 1);

  state_t          state;
  logic [COLS-1:0] shreg;
  logic [CW-1:0]   bit_cnt;
  logic [WW-1:0]   wait_cnt;
  logic            addr_ok;

  // Out-of-range rows only exist when ROWS is not a power of two.
  generate
    if ((1 << AW) == ROWS) begin : g_full_range
      assign addr_ok = 1'b1;
    end else begin : g_part_range
      assign addr_ok = (req_addr < AW'(ROWS));
    end
  endgenerate

  assign serial_out = shreg[0];

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      sram_r_en   <= 1'b0;
      sram_addr   <= '0;
      ser_valid   <= 1'b0;
      ser_last    <= 1'b0;
      addr_err    <= 1'b0;
      timeout_err <= 1'b0;
      shreg       <= '0;
      bit_cnt     <= '0;
      wait_cnt    <= '0;
    end else begin
      addr_err    <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            if (addr_ok) begin
              sram_addr <= req_addr;
              sram_r_en <= 1'b1;
              wait_cnt  <= '0;
              req_ready <= 1'b0;
              state     <= READ;
            end else begin
              addr_err <= 1'b1;
            end
          end
        end
        READ: begin
          // Data arriving on the final wait cycle still wins over the timeout.
          if (sram_data_valid) begin
            shreg     <= sram_data_out;
            sram_r_en <= 1'b0;
            bit_cnt   <= '0;
            ser_valid <= 1'b1;
            ser_last  <= (COLS == 1);
            state     <= SHIFT;
          end else if (wait_cnt == WAIT_MAX) begin
            sram_r_en   <= 1'b0;
            timeout_err <= 1'b1;
            req_ready   <= 1'b1;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (ser_ready) begin
            shreg <= shreg >> 1;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt   <= '0;
              ser_valid <= 1'b0;
              ser_last  <= 1'b0;
              req_ready <= 1'b1;
              state     <= IDLE;
            end else begin
              bit_cnt  <= bit_cnt + 1'b1;
              ser_last <= ((bit_cnt + 1'b1) == LAST_BIT);
            end
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          sram_r_en <= 1'b0;
          ser_valid <= 1'b0;
          ser_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_piso_reader.sv
// Directed bench for sram_piso_reader with a one-cycle-latency SRAM model;
// a second instance with ROWS=12 covers out-of-range requests and a short timeout.
module tb_sram_piso_reader;

  logic       clk = 1'b0;
  logic       arst_n;
  logic       req;
  logic [3:0] req_addr;
  logic       req_ready;
  logic       sram_r_en;
  logic [3:0] sram_addr;
  logic       sram_data_valid;
  logic [7:0] sram_data_out;
  logic       serial_out;
  logic       ser_valid;
  logic       ser_ready;
  logic       ser_last;
  logic       addr_err;
  logic       timeout_err;

  logic       req2;
  logic [3:0] req_addr2;
  logic       req_ready2, sram_r_en2, serial_out2, ser_valid2, ser_last2;
  logic       addr_err2, timeout_err2;
  logic [3:0] sram_addr2;

  logic [7:0] mem [16];
  logic       dv, block_dv, inject;
  logic [7:0] dout, inject_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_piso_reader #(.ROWS(16), .COLS(8), .TIMEOUT(15)) u_dut (
    .clk(clk), .arst_n(arst_n), .req(req), .req_addr(req_addr), .req_ready(req_ready),
    .sram_r_en(sram_r_en), .sram_addr(sram_addr), .sram_data_valid(sram_data_valid),
    .sram_data_out(sram_data_out), .serial_out(serial_out), .ser_valid(ser_valid),
    .ser_ready(ser_ready), .ser_last(ser_last), .addr_err(addr_err),
    .timeout_err(timeout_err)
  );

  sram_piso_reader #(.ROWS(12), .COLS(8), .TIMEOUT(3)) u_dut12 (
    .clk(clk), .arst_n(arst_n), .req(req2), .req_addr(req_addr2), .req_ready(req_ready2),
    .sram_r_en(sram_r_en2), .sram_addr(sram_addr2), .sram_data_valid(1'b0),
    .sram_data_out(8'h00), .serial_out(serial_out2), .ser_valid(ser_valid2),
    .ser_ready(1'b1), .ser_last(ser_last2), .addr_err(addr_err2),
    .timeout_err(timeout_err2)
  );

  // SRAM read model: data and valid one cycle after r_en
  always_ff @(posedge clk) begin
    dv   <= sram_r_en && !block_dv;
    dout <= mem[sram_addr];
  end
  assign sram_data_valid = dv | inject;
  assign sram_data_out   = inject ? inject_data : dout;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_req(input logic [3:0] a);
    @(negedge clk);
    req      = 1'b1;
    req_addr = a;
    @(negedge clk);
    req = 1'b0;
  endtask

  // Collects one frame; beats sa/sb (0-based) are stalled for 3 cycles each.
  task automatic collect(input string tag, input logic [7:0] exp, input int sa, input int sb,
                         output int vc);
    int b = 0;
    int st = 0;
    int guard = 0;
    vc = 0;
    while (b < 8 && guard < 200) begin
      @(negedge clk);
      guard++;
      if (ser_valid) begin
        vc++;
        check({tag, "_bit"}, serial_out, exp[b]);
        check({tag, "_last"}, ser_last, (b == 7));
        if ((b == sa || b == sb) && st < 3) begin
          ser_ready = 1'b0;
          st++;
        end else begin
          ser_ready = 1'b1;
          st = 0;
          b++;
        end
      end
    end
    check({tag, "_frame_done"}, b, 8);
    @(negedge clk);
    check({tag, "_idle_valid"}, ser_valid, 1'b0);
    check({tag, "_idle_last"}, ser_last, 1'b0);
    check({tag, "_idle_ready"}, req_ready, 1'b1);
  endtask

  initial begin
    int vc, rcnt, tcnt, vcnt, guard;
    arst_n = 1'b0; req = 1'b0; req_addr = '0; ser_ready = 1'b1;
    req2 = 1'b0; req_addr2 = '0;
    block_dv = 1'b0; inject = 1'b0; inject_data = '0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem[3] = 8'hA5; mem[7] = 8'h3C; mem[2] = 8'h96; mem[1] = 8'h81;

    // reset state
    #20;
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_r_en", sram_r_en, 1'b0);
    check("rst_ser_valid", ser_valid, 1'b0);
    check("rst_addr_err", addr_err, 1'b0);
    check("rst_timeout_err", timeout_err, 1'b0);
    check("rst_addr", sram_addr, 4'd0);
    @(negedge clk);
    arst_n = 1'b1;

    // basic read, ser_ready held high
    do_req(4'd3);
    check("basic_r_en", sram_r_en, 1'b1);
    check("basic_addr", sram_addr, 4'd3);
    check("basic_busy", req_ready, 1'b0);
    collect("basic", 8'hA5, -1, -1, vc);
    check("basic_cycles", vc, 8);
    check("basic_addr_kept", sram_addr, 4'd3);

    // backpressure on beats 2 and 5
    do_req(4'd7);
    collect("bp", 8'h3C, 1, 4, vc);
    check("bp_cycles", vc, 14);

    // timeout
    block_dv = 1'b1;
    do_req(4'd5);
    rcnt = 0; tcnt = 0; vcnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (i > 0) @(negedge clk);
      if (sram_r_en) rcnt++;
      if (timeout_err) tcnt++;
      if (ser_valid) vcnt++;
    end
    block_dv = 1'b0;
    check("to_r_en_cycles", rcnt, 15);
    check("to_err_pulses", tcnt, 1);
    check("to_no_valid", vcnt, 0);
    check("to_idle", req_ready, 1'b1);

    // request while busy is ignored
    ser_ready = 1'b0;
    do_req(4'd2);
    guard = 0;
    while (!ser_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("busy_reached_shift", ser_valid, 1'b1);
    req = 1'b1; req_addr = 4'd5;
    @(negedge clk);
    req = 1'b0;
    check("busy_no_r_en", sram_r_en, 1'b0);
    check("busy_addr", sram_addr, 4'd2);
    check("busy_not_ready", req_ready, 1'b0);
    collect("busy", 8'h96, -1, -1, vc);
    rcnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (sram_r_en) rcnt++;
    end
    check("busy_no_second_read", rcnt, 0);

    // reset in the middle of a frame
    ser_ready = 1'b0;
    do_req(4'd1);
    guard = 0;
    while (!ser_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("mid_reached_shift", ser_valid, 1'b1);
    arst_n = 1'b0;
    #1;
    check("mid_rst_valid", ser_valid, 1'b0);
    check("mid_rst_ready", req_ready, 1'b1);
    check("mid_rst_serial", serial_out, 1'b0);
    check("mid_rst_addr", sram_addr, 4'd0);
    check("mid_rst_r_en", sram_r_en, 1'b0);
    #19;
    @(negedge clk);
    arst_n = 1'b1;
    ser_ready = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ser_valid) vcnt++;
    end
    check("mid_no_resume", vcnt, 0);

    // out-of-range address and short timeout on the 12-row instance
    @(negedge clk);
    req2 = 1'b1; req_addr2 = 4'd12;
    @(negedge clk);
    req2 = 1'b0;
    check("oor_addr_err", addr_err2, 1'b1);
    check("oor_no_r_en", sram_r_en2, 1'b0);
    check("oor_ready", req_ready2, 1'b1);
    @(negedge clk);
    check("oor_pulse_end", addr_err2, 1'b0);
    req2 = 1'b1; req_addr2 = 4'd11;
    @(negedge clk);
    req2 = 1'b0;
    check("r11_addr_err", addr_err2, 1'b0);
    check("r11_addr", sram_addr2, 4'd11);
    rcnt = 0; tcnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      if (sram_r_en2) rcnt++;
      if (timeout_err2) tcnt++;
    end
    check("r11_r_en_cycles", rcnt, 3);
    check("r11_to_pulses", tcnt, 1);
    check("r11_no_valid", ser_valid2, 1'b0);

    // full sweep with stray data_valid injected while idle
    for (int i = 0; i < 16; i++) mem[i] = 8'(i) ^ 8'h5A;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      inject = 1'b1; inject_data = 8'hFF;
      @(negedge clk);
      inject = 1'b0;
      check("inj_no_valid", ser_valid, 1'b0);
      check("inj_serial", serial_out, 1'b0);
      do_req(4'(i));
      collect($sformatf("sweep%0d", i), 8'(i) ^ 8'h5A, -1, -1, vc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_piso_reader.md
Name: sram_piso_reader

Overview:
Read-side counterpart of the SIPO write path into sram_top. On a request, the block reads one SRAM row and captures the COLS-wide word. It then shifts the word out serially, LSB first, with a valid/ready handshake. It sits between sram_top (r_en/addr/data_valid/data_out) and a downstream serial consumer.

Parameters:
ROWS, 16, number of SRAM rows; address width AW = $clog2(ROWS)
COLS, 8, word width in bits; bit counter width $clog2(COLS)
TIMEOUT, 15, max cycles to wait for data_valid after r_en asserts; must be ≥1

Ports:
clk  input  1  system clock, rising edge
arst_n  input  1  asynchronous active-low reset
req  input  1  read request, qualified by req_ready
req_addr  input  AW  row to read, sampled on accept
req_ready  output  1  high only in IDLE
sram_r_en  output  1  read enable to sram_top
sram_addr  output  AW  row address to sram_top
sram_data_valid  input  1  sram_top read data valid
sram_data_out  input  COLS  sram_top read data
serial_out  output  1  current serial bit
ser_valid  output  1  serial_out is valid
ser_ready  input  1  consumer accepts the current bit
ser_last  output  1  current bit is bit COLS-1
addr_err  output  1  one-cycle pulse: request rejected, req_addr ≥ ROWS
timeout_err  output  1  one-cycle pulse: data_valid never arrived

Behaviour:
- Reset (asynchronous, arst_n=0): state=IDLE. req_ready=1. All other outputs 0, including sram_addr. Shift register, bit counter and wait counter are cleared. A reset during a read or a shift abandons the frame; no partial completion occurs after release.
- FSM states: IDLE, READ, SHIFT. All outputs are registered.
- IDLE:
  - A request is accepted when req && req_ready.
  - If req_addr < ROWS: latch the address into sram_addr, go to READ, set sram_r_en=1 in the next cycle, and clear the wait counter.
  - If req_addr ≥ ROWS: pulse addr_err for 1 cycle and stay in IDLE. This case is only reachable when ROWS is not a power of 2.
- READ:
  - sram_r_en=1 and sram_addr are held stable.
  - The wait counter increments each cycle.
  - On the edge where sram_data_valid=1: capture sram_data_out into the shift register, drop sram_r_en, go to SHIFT, and clear the bit counter.
  - If the counter reaches TIMEOUT without data_valid: drop sram_r_en, pulse timeout_err for 1 cycle, and return to IDLE. No serial output is produced.
  - If data_valid coincides with the timeout cycle, data wins: no error, go to SHIFT.
- SHIFT:
  - ser_valid=1 and serial_out=shreg[0].
  - On ser_ready=1: shift right by one and increment the bit counter. On ser_ready=0: hold all shift state.
  - ser_last=1 while the bit counter = COLS-1.
  - When the last bit is accepted, go to IDLE. In the next cycle ser_valid=0, ser_last=0, req_ready=1.
- Minimum latency, req accept to first ser_valid: 1 cycle (r_en) + SRAM read latency + 1 cycle (capture).
- A full frame takes exactly COLS accepted beats. Bit order is word[0] first.
- req in READ/SHIFT is ignored (req_ready=0); there is no queueing.
- sram_data_valid outside READ is ignored, and the shift register does not change.
- sram_addr retains the last accepted address after the read. It is not cleared.
- Counters saturate or clear as above and never wrap mid-state.

Test Plan:
- Reset then idle: arst_n low 20 ns → req_ready=1; sram_r_en, ser_valid, addr_err and timeout_err are all 0. Assert arst_n=0 mid-SHIFT → all outputs return to reset values immediately.
- Basic read: write 8'hA5 to row 3 via the SIPO path, then req with req_addr=3 and ser_ready tied to 1 → sram_r_en=1, sram_addr=3 until data_valid. Serial stream is 1,0,1,0,0,1,0,1 on consecutive cycles; ser_last is on the 8th bit; req_ready=1 in the following cycle.
- Backpressure: read row 7 = 8'h3C, with ser_ready=0 on beats 2 and 5 for 3 cycles each → serial_out and ser_valid are held. Bits are delivered exactly once (0,0,1,1,1,1,0,0), and the frame takes 14 cycles.
- Timeout: sram_data_valid forced 0, TIMEOUT=15 → sram_r_en is high for exactly 15 cycles, timeout_err pulses once, ser_valid never asserts, and the block returns to IDLE.
- Request during busy: pulse req with addr=5 while in SHIFT for row 2 → ignored. Row 2 completes, and no second read is issued.
- Full sweep: write a distinct pattern (row index XOR 8'h5A) to rows 0–15, then read every row → each serialized word equals the reference memory. data_valid injected outside READ has no effect.
